// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI responder.
package spi_pkg;
  localparam int unsigned SPI_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with registered rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  // Data stages are left unreset so a held reset flushes them with the live pin level.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
    if (arst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = prev_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/spi_slave.sv
// SPI responder, all CPOL/CPHA modes, LSB-first, oversampled in the clk domain.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy,
  input  logic              cs,
  input  logic              sclk,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_oe
);
  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .arst(arst), .d(cs), .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .arst(arst), .d(sclk), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk(clk), .arst(arst), .d(MOSI), .q(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_t        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              need_start_q, need_start_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              frame_abort_q, frame_abort_d;
  logic              busy_q, busy_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;

  logic              lead, trail, sample_ev, shift_ev, word_start, present;
  logic [DATA_W-1:0] word, rx_next;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    tx_buf_d      = tx_buf_q;
    tx_ready_d    = tx_ready_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    bit_cnt_d     = bit_cnt_q;
    need_start_d  = need_start_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    miso_d        = miso_q;
    word_start    = 1'b0;
    present       = 1'b0;
    word          = '0;
    rx_next       = {mosi_lvl, rx_sh_q[DATA_W-1:1]};
    lead          = mode_q.cpol ? sclk_fall : sclk_rise;
    trail         = mode_q.cpol ? sclk_rise : sclk_fall;
    sample_ev     = mode_q.cpha ? trail : lead;
    shift_ev      = mode_q.cpha ? lead : trail;

    case (state_q)
      WAIT_CS: if (cs_lvl) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_d      = SHIFT;
          mode_d.cpol  = cpol;
          mode_d.cpha  = cpha;
          word_start   = 1'b1;
          present      = ~cpha;
          bit_cnt_d    = '0;
          rx_sh_d      = '0;
          need_start_d = 1'b0;
        end
      end
      SHIFT: begin
        if (sample_ev) begin
          rx_sh_d = rx_next;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rx_data_d    = rx_next;
            rx_valid_d   = 1'b1;
            bit_cnt_d    = '0;
            need_start_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        // The edge that would present a new word's first bit starts that word.
        if (shift_ev) begin
          if (need_start_q) begin
            word_start   = 1'b1;
            present      = 1'b1;
            need_start_d = 1'b0;
          end else begin
            miso_d  = tx_sh_q[0];
            tx_sh_d = tx_sh_q >> 1;
          end
        end
        if (cs_rise) begin
          state_d       = IDLE;
          frame_abort_d = (bit_cnt_d != '0);
          bit_cnt_d     = '0;
          rx_sh_d       = '0;
          need_start_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_start) begin
      if (tx_ready_q) begin
        word          = '0;
        tx_underrun_d = 1'b1;
      end else begin
        word       = tx_buf_q;
        tx_ready_d = 1'b1;
      end
      if (present) begin
        miso_d  = word[0];
        tx_sh_d = word >> 1;
      end else begin
        tx_sh_d = word;
      end
    end

    // Handshake after word start so a same-cycle offer is kept for the next word.
    if (tx_valid && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end

    if (state_d != SHIFT) miso_d = 1'b0;
    miso_oe_d = (state_d == SHIFT);
    busy_d    = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q       <= cs_lvl ? IDLE : WAIT_CS;
      mode_q        <= '0;
      tx_buf_q      <= '0;
      tx_ready_q    <= 1'b1;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      bit_cnt_q     <= '0;
      need_start_q  <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
      busy_q        <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      tx_buf_q      <= tx_buf_d;
      tx_ready_q    <= tx_ready_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      bit_cnt_q     <= bit_cnt_d;
      need_start_q  <= need_start_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
      busy_q        <= busy_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;
  assign busy        = busy_q;
  assign MISO        = miso_q;
  assign MISO_oe     = miso_oe_q;
endmodule

// File: doc/spi_slave.md
# spi_slave

Single-clock SPI responder: the far end of the `master` link, on the other side of `cs`/`sclk`/`MOSI`/`MISO`. It oversamples the SPI pins in the system clock domain and supports all four CPOL/CPHA modes. Bytes are transferred LSB-first, matching `master`. It deserialises `MOSI` into parallel bytes and serialises a buffered byte onto `MISO`, with a valid/ready load handshake and multi-byte frames while `cs` stays low.

## Interface
- `DATA_W`, 8: bits per word.
- `SYNC_STAGES`, 2: flip-flop stages on each asynchronous SPI input; must be ≥ 2.
- `clk` input 1: system clock; all logic is on its rising edge.
- `arst` input 1: reset, synchronous and active-high.
- `cpol` input 1: SCLK idle level.
- `cpha` input 1: 0 = sample on the leading edge; 1 = sample on the trailing edge.
- `tx_data` input DATA_W: next word to send.
- `tx_valid` input 1: `tx_data` is offered.
- `tx_ready` output 1: the TX buffer is empty; a word is accepted when `tx_valid && tx_ready`.
- `rx_data` output DATA_W: last complete received word; holds until the next word completes.
- `rx_valid` output 1: one-cycle strobe when `rx_data` updates.
- `tx_underrun` output 1: one-cycle pulse when a word starts with the buffer empty.
- `frame_abort` output 1: one-cycle pulse when `cs` rises with a partial word in progress.
- `busy` output 1: a frame is active (state SHIFT).
- `cs` input 1: chip select, active-low, asynchronous.
- `sclk` input 1: SPI clock, asynchronous.
- `MOSI` input 1: master data in.
- `MISO` output 1: slave data out.
- `MISO_oe` output 1: drive enable for `MISO`; the top level builds the tristate.

## Operation
- `cs`, `sclk` and `MOSI` each pass through SYNC_STAGES flip-flops. Edges are detected on the synchronised `cs` and `sclk` by comparing each with its previous value.
- Leading edge = `sclk` leaves its idle level (rising if `cpol`=0). Trailing edge = `sclk` returns to idle.
- `cpol` and `cpha` are latched when the `cs` falling edge is detected. Changes to them mid-frame are ignored.
- FSM states:
  - IDLE → SHIFT on the synchronised `cs` falling edge.
  - SHIFT → IDLE on the synchronised `cs` rising edge.
  - WAIT_CS: entered from reset if `cs` is low. Moves to IDLE once `cs` is seen high. A frame already in progress at reset is ignored.
- Word start (the `cs` fall, and every word boundary while `cs` stays low):
  - If the buffer is full, move the buffer into the TX shift register; the buffer empties and `tx_ready` rises.
  - If the buffer is empty, load 0x00 into the shift register and pulse `tx_underrun`.
  - `bit_cnt` = 0.
- CPHA=0: `MISO` = bit 0 from the word start. On each trailing edge, shift right and present the next bit. Sample `MOSI` on each leading edge.
- CPHA=1: on each leading edge, present the next bit; the first leading edge of a word presents bit 0. Sample `MOSI` on each trailing edge.
- Each sample shifts `MOSI` into the RX shift register MSB-side (so bit 0 lands in bit 0 after 8 samples) and increments `bit_cnt`.
- When `bit_cnt` reaches DATA_W:
  - `rx_data` is updated and `rx_valid` pulses.
  - `bit_cnt` wraps to 0.
  - The next word start happens at the edge that would present its first bit: the next trailing edge for CPHA=0, the next leading edge for CPHA=1.
- `cs` rise with `bit_cnt` ≠ 0: pulse `frame_abort`, discard the partial RX word, no `rx_valid`. A buffered TX word stays buffered.
- `MISO_oe` = 1 only in SHIFT. `MISO` = 0 whenever `MISO_oe` = 0.
- A completed word is never lost: `rx_valid` is a strobe with no backpressure, and the consumer must take it in that cycle.

## Timing
- Reset values: `MISO` 0, `MISO_oe` 0, `rx_data` 0, `rx_valid` 0, `tx_ready` 1, `tx_underrun` 0, `frame_abort` 0, `busy` 0. Reset also clears the buffer and all counters.
- Pin-to-detect latency: SYNC_STAGES+1 `clk` cycles.
- `MISO` updates 1 cycle after an edge is detected, which is SYNC_STAGES+2 cycles after the pin edge.
- Required SCLK half-period ≥ SYNC_STAGES+2 `clk` cycles. This is met by `master` (half-period of 4 `clk` cycles with the default of 2 stages).
- `rx_valid` asserts the cycle after the final sample edge is detected.
- `tx_ready` drops the cycle after the handshake. It rises the cycle after the buffer is consumed.
- A handshake in the same cycle as a word start: the buffer content at the start of that cycle is used. The new word is stored and is used at the following word start.
- `cs` rise and a final sample detected in the same cycle: the sample completes the word (`rx_valid` pulses), then the FSM goes to IDLE with no `frame_abort`.

## Structure
- Package `spi_pkg`:
  - `SPI_DATA_W` = 8.
  - `spi_state_t` enum with values IDLE, SHIFT, WAIT_CS.
  - `spi_mode_t` packed struct holding cpol and cpha.
- Sub-module `spi_sync_edge`: parameterised synchroniser with rise/fall pulse outputs, instantiated for `cs` and `sclk`. `MOSI` uses the synchroniser only.

## Test plan
- Mode 0: preload 0xA5, then `master` sends 0x3C → `rx_data` = 0x3C with one `rx_valid`; the `master` receives 0xA5.
- Modes 1, 2, 3: exchange 0x81 / 0x7E in each mode → both sides receive the correct word; `MISO_oe` is low outside `cs`.
- Two-word frame (`cs` held low for 16 bits) with 0x11 and 0x22 loaded in turn → `master` receives 0x11 then 0x22; two `rx_valid` pulses.
- No TX word loaded → `tx_underrun` pulses once; `MISO` sends 0x00; RX still correct.
- `cs` raised after 5 bits → `frame_abort` pulses; no `rx_valid`; the next full frame completes correctly.
- `arst` asserted mid-frame → all outputs at reset values; the rest of the frame is ignored; the next frame completes correctly.
